// File: rtl/rv_pkg.sv
// Shared RV fetch-path types and constants.
package rv_pkg;
  localparam int          XLEN             = 32;
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // One buffered fetch: the PC it was read from and the returned word.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, instr} entries; flush wins over push/pop.
module fetch_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t din,
  input  logic         pop,
  output fetch_entry_t dout,
  output logic [CW-1:0] count
);
  fetch_entry_t        mem_q [DEPTH];
  fetch_entry_t        mem_d [DEPTH];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

  // Next-state: flush clears pointers; otherwise push writes tail, pop advances head.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // The issue logic reserves a slot for every in-flight read, so this never fires.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !flush && !pop && count_q == CW'(DEPTH)));
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, credit-limited issue, redirect/flush, buffer to decode.
module fetch_stage
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            do_branch,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int LW = CW + 1;

  logic [XLEN-1:0] pc_q, pc_d, req_pc_q, req_pc_d;
  logic            outstanding_q, outstanding_d;
  logic            push, pop, empty;
  logic [CW-1:0]   count;
  logic [LW-1:0]   level, limit;
  fetch_entry_t    head, tail_in;
  logic            tgt_lo_unused;

  // Low target bits are forced to zero; keep them visibly consumed.
  assign tgt_lo_unused = ^branch_target[1:0];

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (do_branch),
    .push  (push),
    .din   (tail_in),
    .pop   (pop),
    .dout  (head),
    .count (count)
  );

  // Handshake, issue credit and next PC; redirect overrides everything.
  always_comb begin
    empty    = (count == '0);
    id_valid = !empty && !do_branch;
    pop      = id_valid && id_ready;
    push     = imem_rvalid && !do_branch;
    tail_in  = '{pc: req_pc_q, instr: imem_rdata};
    // Words buffered plus the one in flight must leave room for a new read.
    level    = LW'(count) + LW'(outstanding_q);
    limit    = LW'(FIFO_DEPTH) + LW'(pop);
    imem_req = !rst && !do_branch && (level < limit);
    imem_addr = pc_q;
    id_instr = empty ? INSTR_NOP : head.instr;
    id_pc    = empty ? pc_q : head.pc;

    pc_d          = pc_q;
    req_pc_d      = req_pc_q;
    outstanding_d = imem_req;
    if (do_branch) begin
      pc_d = {branch_target[XLEN-1:2], 2'b00};
    end else if (imem_req) begin
      pc_d     = pc_q + 32'd4;
      req_pc_d = pc_q;
    end
  end

  // PC and in-flight tracking registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      req_pc_q      <= RESET_PC;
      outstanding_q <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      req_pc_q      <= req_pc_d;
      outstanding_q <= outstanding_d;
    end
  end

  // Memory must only answer a request issued the previous cycle.
  a_rvalid_has_req: assert property (@(posedge clk) disable iff (rst)
    imem_rvalid |-> outstanding_q);
endmodule
